// File: rtl/button_pkg.sv
// Shared types and helpers for the pushbutton front end.
package button_pkg;

    // Per-button debounce FSM state.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        PRESSED   = 2'd2,
        RELEASING = 2'd3
    } btn_state_t;

    // Counter width wide enough for the largest cycle count, plus one spare bit so
    // HOLD_CYCLES + REPEAT_CYCLES also fits.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return unsigned'($clog2(m)) + 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, debounce FSM, and optional hold-to-repeat counter.
// pulse_req is combinational and is registered by the parent.
module btn_debounce
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter bit          REPEAT_EN       = 1'b0,
    parameter int unsigned HOLD_CYCLES     = 25000000,
    parameter int unsigned REPEAT_CYCLES   = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic pulse_req
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);

    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_SAT   = '1;
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_BASE = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] WRAP_LAST = CW'(HOLD_CYCLES + REPEAT_CYCLES - 1);

    logic          sync1_q, sync2_q;
    btn_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CW-1:0] hold_q, hold_d, hold_inc;
    logic          level_q, level_d;

    // Two-stage synchroniser for the asynchronous button input.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Saturating increments.
    assign cnt_inc  = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;
    assign hold_inc = (hold_q == CNT_SAT) ? hold_q : hold_q + CNT_ONE;

    // Next-state logic; a request fires on the edge the counter reaches its target.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        level_d   = level_q;
        pulse_req = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = ARMING;
                    cnt_d   = CNT_ONE;
                end
            end
            ARMING: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= DEB_LAST) begin
                    state_d   = PRESSED;
                    cnt_d     = '0;
                    hold_d    = '0;
                    level_d   = 1'b1;
                    pulse_req = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            PRESSED: begin
                if (!sync2_q) begin
                    state_d = RELEASING;
                    cnt_d   = CNT_ONE;
                end else if (REPEAT_EN) begin
                    // Counter climbs to HOLD_CYCLES, then cycles HOLD..HOLD+REPEAT-1.
                    if (hold_q == WRAP_LAST) begin
                        hold_d    = HOLD_BASE;
                        pulse_req = 1'b1;
                    end else if (hold_q == HOLD_LAST) begin
                        hold_d    = hold_inc;
                        pulse_req = 1'b1;
                    end else begin
                        hold_d = hold_inc;
                    end
                end
            end
            RELEASING: begin
                // Hold counter is frozen here so a release glitch resumes the repeat cadence.
                if (sync2_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q >= DEB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    hold_d  = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                hold_d  = '0;
                level_d = 1'b0;
            end
        endcase
    end

    // FSM and counter state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/button_pulse_gen.sv
// Debounces the up/down pushbuttons and emits single-cycle, mutually exclusive
// up/down command pulses for the counter.
module button_pulse_gen
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter bit          REPEAT_EN       = 1'b0,
    parameter int unsigned HOLD_CYCLES     = 25000000,
    parameter int unsigned REPEAT_CYCLES   = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    output logic up,
    output logic down,
    output logic up_level,
    output logic down_level
);

    logic up_req;
    logic down_req;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_EN       (REPEAT_EN),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_up (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_up_raw),
        .level     (up_level),
        .pulse_req (up_req)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_EN       (REPEAT_EN),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_down (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_down_raw),
        .level     (down_level),
        .pulse_req (down_req)
    );

    // Register the pulses; coincident requests cancel so up and down never overlap.
    always_ff @(posedge clk) begin
        if (reset) begin
            up   <= 1'b0;
            down <= 1'b0;
        end else begin
            up   <= up_req & ~down_req;
            down <= down_req & ~up_req;
        end
    end

endmodule

// File: tb/tb_button_pulse_gen.sv
// Directed bench for button_pulse_gen with DEBOUNCE=4, HOLD=10, REPEAT=5.
// Vector "edge n" means inputs driven before rising edge n, outputs sampled 1 ns after it.
module tb_button_pulse_gen;

    localparam int unsigned DEB  = 4;
    localparam int unsigned HOLD = 10;
    localparam int unsigned REP  = 5;

    logic clk = 1'b0;
    logic reset;
    logic up_raw, down_raw;
    logic up, down, up_level, down_level;
    logic rep_up_raw, rep_down_raw;
    logic rep_up, rep_down, rep_up_level, rep_down_level;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    button_pulse_gen #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_EN       (1'b0),
        .HOLD_CYCLES     (HOLD),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_up_raw   (up_raw),
        .btn_down_raw (down_raw),
        .up           (up),
        .down         (down),
        .up_level     (up_level),
        .down_level   (down_level)
    );

    button_pulse_gen #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_EN       (1'b1),
        .HOLD_CYCLES     (HOLD),
        .REPEAT_CYCLES   (REP)
    ) dut_rep (
        .clk          (clk),
        .reset        (reset),
        .btn_up_raw   (rep_up_raw),
        .btn_down_raw (rep_down_raw),
        .up           (rep_up),
        .down         (rep_down),
        .up_level     (rep_up_level),
        .down_level   (rep_down_level)
    );

    // One record applies the same inputs for `rep` cycles, expecting the same outputs each cycle.
    typedef struct {
        int   rep;
        logic ur;
        logic dr;
        logic e_up;
        logic e_down;
        logic e_upl;
        logic e_dnl;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int rep, input logic ur, input logic dr, input logic e_up,
                                input logic e_down, input logic e_upl, input logic e_dnl);
        vec_t v;
        v.rep = rep; v.ur = ur; v.dr = dr;
        v.e_up = e_up; v.e_down = e_down; v.e_upl = e_upl; v.e_dnl = e_dnl;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic ur, input logic dr, input logic rst);
        up_raw   = ur;
        down_raw = dr;
        reset    = rst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        up_raw       = 1'b0;
        down_raw     = 1'b0;
        rep_up_raw   = 1'b0;
        rep_down_raw = 1'b0;
        reset        = 1'b1;

        // Reset state
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("rst up", up, 1'b0);
        check("rst down", down, 1'b0);
        check("rst up_level", up_level, 1'b0);
        check("rst down_level", down_level, 1'b0);
        check("rst rep_up", rep_up, 1'b0);
        check("rst rep_up_level", rep_up_level, 1'b0);

        // Clean up press held 20 cycles: pulse at edge 5, level 5..24.
        add(5,  1, 0, 0, 0, 0, 0);
        add(1,  1, 0, 1, 0, 1, 0);
        add(14, 1, 0, 0, 0, 1, 0);
        add(5,  0, 0, 0, 0, 1, 0);
        add(3,  0, 0, 0, 0, 0, 0);
        // Down bounce 1,0,1,1,0 then held: one pulse at edge 10.
        add(1,  0, 1, 0, 0, 0, 0);
        add(1,  0, 0, 0, 0, 0, 0);
        add(2,  0, 1, 0, 0, 0, 0);
        add(1,  0, 0, 0, 0, 0, 0);
        add(5,  0, 1, 0, 0, 0, 0);
        add(1,  0, 1, 0, 1, 0, 1);
        add(5,  0, 1, 0, 0, 0, 1);
        add(5,  0, 0, 0, 0, 0, 1);
        add(3,  0, 0, 0, 0, 0, 0);
        // Up press followed by two 2-cycle release glitches: level holds, no extra pulse.
        add(5,  1, 0, 0, 0, 0, 0);
        add(1,  1, 0, 1, 0, 1, 0);
        add(3,  1, 0, 0, 0, 1, 0);
        add(2,  0, 0, 0, 0, 1, 0);
        add(3,  1, 0, 0, 0, 1, 0);
        add(2,  0, 0, 0, 0, 1, 0);
        add(5,  1, 0, 0, 0, 1, 0);
        add(5,  0, 0, 0, 0, 1, 0);
        add(3,  0, 0, 0, 0, 0, 0);
        // Simultaneous press: both requests dropped, both levels rise at edge 5.
        add(5,  1, 1, 0, 0, 0, 0);
        add(3,  1, 1, 0, 0, 1, 1);
        add(5,  0, 0, 0, 0, 1, 1);
        add(3,  0, 0, 0, 0, 0, 0);
        // Staggered press: up at edge 5, down (rose 2 later) at edge 7.
        add(2,  1, 0, 0, 0, 0, 0);
        add(3,  1, 1, 0, 0, 0, 0);
        add(1,  1, 1, 1, 0, 1, 0);
        add(1,  1, 1, 0, 0, 1, 0);
        add(1,  1, 1, 0, 1, 1, 1);
        add(2,  1, 1, 0, 0, 1, 1);
        add(5,  0, 0, 0, 0, 1, 1);
        add(3,  0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            for (int c = 0; c < vecs[i].rep; c++) begin
                step(vecs[i].ur, vecs[i].dr, 1'b0);
                check($sformatf("vec%0d.%0d up", i, c), up, vecs[i].e_up);
                check($sformatf("vec%0d.%0d down", i, c), down, vecs[i].e_down);
                check($sformatf("vec%0d.%0d up_level", i, c), up_level, vecs[i].e_upl);
                check($sformatf("vec%0d.%0d down_level", i, c), down_level, vecs[i].e_dnl);
            end
        end

        // Hold-to-repeat: press pulse at 5, repeats at 15 then every 5; released before edge 40.
        for (int e = 0; e < 48; e++) begin
            rep_up_raw = (e < 40);
            @(posedge clk);
            #1;
            check($sformatf("repeat e%0d up", e), rep_up,
                  (e == 5 || e == 15 || e == 20 || e == 25 || e == 30 || e == 35 || e == 40));
            check($sformatf("repeat e%0d down", e), rep_down, 1'b0);
            check($sformatf("repeat e%0d up_level", e), rep_up_level, (e >= 5 && e < 45));
        end

        // Reset mid-hold: reset at edge 8, fresh press pulse at edge 14.
        for (int e = 0; e < 8; e++) begin
            step(1'b1, 1'b0, 1'b0);
            check($sformatf("rsthold e%0d up", e), up, (e == 5));
        end
        step(1'b1, 1'b0, 1'b1);
        check("rsthold e8 up", up, 1'b0);
        check("rsthold e8 down", down, 1'b0);
        check("rsthold e8 up_level", up_level, 1'b0);
        check("rsthold e8 down_level", down_level, 1'b0);
        for (int e = 9; e < 18; e++) begin
            step(1'b1, 1'b0, 1'b0);
            check($sformatf("rsthold e%0d up", e), up, (e == 14));
            check($sformatf("rsthold e%0d up_level", e), up_level, (e >= 14));
            check($sformatf("rsthold e%0d down", e), down, 1'b0);
        end
        for (int e = 0; e < 8; e++) begin
            step(1'b0, 1'b0, 1'b0);
            check($sformatf("rsthold rel%0d up", e), up, 1'b0);
        end
        check("rsthold final up_level", up_level, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
